unified_cache_bank_router: RTL

- Parametrised request/return crossbar between NUM_INPUT_PORT requesters and NUM_BANK unified-cache banks.
- Each input port has a FIFO. Requests are routed to a bank by address bits, with round-robin arbitration per bank and a registered output stage per bank.
- Bank returns are routed back to the requesting port by the packet port-number field, with round-robin arbitration per port.
- Replaces the fixed two-arbiter glue in front of the cache banks. Adds configurable depth, bank and port counts, and detection of bad port IDs.

---
 rtl/unified_cache_bank_router.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/unified_cache_bank_router.sv
// unified_cache_bank_router
//   Request/return crossbar between NUM_INPUT_PORT requesters and NUM_BANK
//   unified-cache banks.
//   - Requests: a FIFO per port, routed by address bank-select bits,
//     round-robin per bank, registered output per bank.
//   - Returns: routed by the packet port-number field, round-robin per port,
//     registered output per port. Returns carrying an out-of-range port ID are
//     acked, dropped and flagged on the sticky route_error_out.
//   Optional feature macro: UNIFIED_CACHE_ROUTER_CRITICAL_PRIORITY_EN
//     (defined: ports with a full FIFO win bank arbitration over the others).
// Ports:
//   clk_in, reset_in (async, active low)
//   input_packet_flatted_in / _ack_ / input_queue_full_flatted_out : requesters
//   to_bank_packet_flatted_out / to_bank_packet_ack_flatted_in      : bank requests
//   from_bank_packet_flatted_in / from_bank_packet_ack_flatted_out  : bank returns
//   output_packet_flatted_out / output_packet_ack_flatted_in        : port returns
//   route_error_out : sticky bad-return-ID flag

`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 32
`endif
`ifndef UNIFIED_CACHE_PACKET_VALID_POS
`define UNIFIED_CACHE_PACKET_VALID_POS 31
`endif
`ifndef UNIFIED_CACHE_PACKET_PORT_NUM_LO
`define UNIFIED_CACHE_PACKET_PORT_NUM_LO 24
`endif
`ifndef UNIFIED_CACHE_PACKET_ADDR_LO
`define UNIFIED_CACHE_PACKET_ADDR_LO 0
`endif
`ifndef UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES
`define UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES 16
`endif

// Round-robin pick: first requester at or after ptr, wrapping.
module unified_cache_router_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++)
      if (!gnt_vld && req[i] && i >= int'(ptr)) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
    for (int i = 0; i < N; i++)
      if (!gnt_vld && req[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(i);
      end
  end
endmodule

// Input FIFO. When empty the incoming packet is presented as head in the
// same cycle, so an ack in cycle N can reach the bank register by N+1.
// A bypassed push+pop writes and advances both pointers; count is unchanged.
module unified_cache_router_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_vld,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW:0] CNT_MAX = DEPTH;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt, cnt_nxt;
  logic          empty;

  assign empty    = (cnt == '0);
  assign head_vld = !empty || push;
  assign head     = empty ? din : mem[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CNT_ONE;
    else if (pop && !push) cnt_nxt = cnt - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == CNT_MAX);
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

module unified_cache_bank_router #(
  parameter int NUM_INPUT_PORT = 2,
  parameter int NUM_BANK       = 4,
  parameter int PACKET_WIDTH   = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
  parameter int QUEUE_DEPTH    = 4,
  parameter int VALID_POS      = `UNIFIED_CACHE_PACKET_VALID_POS,
  parameter int PORT_NUM_LO    = `UNIFIED_CACHE_PACKET_PORT_NUM_LO,
  parameter int BANK_SEL_LO    = `UNIFIED_CACHE_PACKET_ADDR_LO + $clog2(`UNIFIED_CACHE_BLOCK_SIZE_IN_BYTES)
) (
  input  logic                                 clk_in,
  input  logic                                 reset_in,
  input  logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] input_packet_flatted_in,
  output logic [NUM_INPUT_PORT-1:0]            input_packet_ack_flatted_out,
  output logic [NUM_INPUT_PORT-1:0]            input_queue_full_flatted_out,
  output logic [NUM_BANK*PACKET_WIDTH-1:0]     to_bank_packet_flatted_out,
  input  logic [NUM_BANK-1:0]                  to_bank_packet_ack_flatted_in,
  input  logic [NUM_BANK*PACKET_WIDTH-1:0]     from_bank_packet_flatted_in,
  output logic [NUM_BANK-1:0]                  from_bank_packet_ack_flatted_out,
  output logic [NUM_INPUT_PORT*PACKET_WIDTH-1:0] output_packet_flatted_out,
  input  logic [NUM_INPUT_PORT-1:0]            output_packet_ack_flatted_in,
  output logic                                 route_error_out
);
  localparam int P    = NUM_INPUT_PORT;
  localparam int B    = NUM_BANK;
  localparam int W    = PACKET_WIDTH;
  localparam int PIDW = (P > 1) ? $clog2(P) : 1;
  localparam int BSW  = (B > 1) ? $clog2(B) : 1;

  // request side
  logic [P-1:0][W-1:0]    in_pkt, head;
  logic [P-1:0]           in_ack, head_vld, q_full, pop;
  logic [P-1:0][BSW-1:0]  tgt;
  logic [B-1:0][P-1:0]    bank_req;
  logic [B-1:0]           bank_free, bank_gv;
  logic [B-1:0][PIDW-1:0] bank_gi, rr_req;
  logic [B-1:0][W-1:0]    to_bank_q, bank_din;
  // return side
  logic [B-1:0][W-1:0]    from_bank;
  logic [B-1:0][PIDW-1:0] ret_dest;
  logic [B-1:0]           ret_vld, bad, fb_ack;
  logic [P-1:0][B-1:0]    ret_req;
  logic [P-1:0]           out_free, ret_gv;
  logic [P-1:0][BSW-1:0]  ret_gi, rr_ret;
  logic [P-1:0][W-1:0]    out_q, out_din;
  logic                   route_err;

  function automatic logic [PIDW-1:0] inc_p(input logic [PIDW-1:0] i);
    return (int'(i) + 1 >= P) ? '0 : i + PIDW'(1);
  endfunction

  function automatic logic [BSW-1:0] inc_b(input logic [BSW-1:0] i);
    return (int'(i) + 1 >= B) ? '0 : i + BSW'(1);
  endfunction

  assign in_pkt    = input_packet_flatted_in;
  assign from_bank = from_bank_packet_flatted_in;

  // ---------------- request path ----------------
  for (genvar p = 0; p < P; p++) begin : g_port
    assign in_ack[p] = reset_in && in_pkt[p][VALID_POS] && !q_full[p];
    assign tgt[p]    = head[p][BANK_SEL_LO +: BSW];

    unified_cache_router_fifo #(.W(W), .DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk      (clk_in),
      .rst_n    (reset_in),
      .push     (in_ack[p]),
      .din      (in_pkt[p]),
      .pop      (pop[p]),
      .head     (head[p]),
      .head_vld (head_vld[p]),
      .full     (q_full[p])
    );
  end

  always_comb begin
    bank_req = '0;
    for (int b = 0; b < B; b++)
      for (int p = 0; p < P; p++)
        bank_req[b][p] = head_vld[p] && (B == 1 || tgt[p] == BSW'(b));
  end

  for (genvar b = 0; b < B; b++) begin : g_bank
    logic [P-1:0] req_m, arb_req;
`ifdef UNIFIED_CACHE_ROUTER_CRITICAL_PRIORITY_EN
    // A full FIFO marks its port critical; critical requesters shadow the rest.
    logic [P-1:0] crit;
    assign crit  = bank_req[b] & q_full;
    assign req_m = (|crit) ? crit : bank_req[b];
`else
    assign req_m = bank_req[b];
`endif
    // Free when empty or being drained this cycle: back-to-back 1/cycle.
    assign bank_free[b] = !to_bank_q[b][VALID_POS] || to_bank_packet_ack_flatted_in[b];
    assign arb_req      = bank_free[b] ? req_m : '0;

    unified_cache_router_rr_arb #(.N(P), .IW(PIDW)) u_arb (
      .req     (arb_req),
      .ptr     (rr_req[b]),
      .gnt_vld (bank_gv[b]),
      .gnt_idx (bank_gi[b])
    );
  end

  // A port's head targets a single bank, so at most one pop per port.
  always_comb begin
    pop      = '0;
    bank_din = '0;
    for (int b = 0; b < B; b++)
      for (int p = 0; p < P; p++)
        if (bank_gv[b] && bank_gi[b] == PIDW'(p)) begin
          pop[p]      = 1'b1;
          bank_din[b] = head[p];
        end
  end

  // ---------------- return path ----------------
  for (genvar b = 0; b < B; b++) begin : g_ret
    assign ret_vld[b]  = from_bank[b][VALID_POS];
    assign ret_dest[b] = from_bank[b][PORT_NUM_LO +: PIDW];
    assign bad[b]      = ret_vld[b] && int'(ret_dest[b]) >= P;
  end

  always_comb begin
    ret_req = '0;
    for (int p = 0; p < P; p++)
      for (int b = 0; b < B; b++)
        ret_req[p][b] = ret_vld[b] && !bad[b] && ret_dest[b] == PIDW'(p);
  end

  for (genvar p = 0; p < P; p++) begin : g_out
    logic [B-1:0] arb_req;
    assign out_free[p] = !out_q[p][VALID_POS] || output_packet_ack_flatted_in[p];
    assign arb_req     = out_free[p] ? ret_req[p] : '0;

    unified_cache_router_rr_arb #(.N(B), .IW(BSW)) u_arb (
      .req     (arb_req),
      .ptr     (rr_ret[p]),
      .gnt_vld (ret_gv[p]),
      .gnt_idx (ret_gi[p])
    );
  end

  // Bad-ID returns are acked on sight so the bank is never stuck on them.
  always_comb begin
    fb_ack  = bad;
    out_din = '0;
    for (int p = 0; p < P; p++)
      for (int b = 0; b < B; b++)
        if (ret_gv[p] && ret_gi[p] == BSW'(b)) begin
          fb_ack[b]  = 1'b1;
          out_din[p] = from_bank[b];
        end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk_in or negedge reset_in)
    if (!reset_in) begin
      to_bank_q <= '0;
      rr_req    <= '0;
      out_q     <= '0;
      rr_ret    <= '0;
      route_err <= 1'b0;
    end else begin
      for (int b = 0; b < B; b++)
        if (bank_gv[b]) begin
          to_bank_q[b] <= bank_din[b];
          rr_req[b]    <= inc_p(bank_gi[b]);
        end else if (to_bank_packet_ack_flatted_in[b]) begin
          to_bank_q[b] <= '0;
        end
      for (int p = 0; p < P; p++)
        if (ret_gv[p]) begin
          out_q[p]  <= out_din[p];
          rr_ret[p] <= inc_b(ret_gi[p]);
        end else if (output_packet_ack_flatted_in[p]) begin
          out_q[p] <= '0;
        end
      if (|bad) route_err <= 1'b1;
    end

  assign input_packet_ack_flatted_out     = in_ack;
  assign input_queue_full_flatted_out     = q_full;
  assign to_bank_packet_flatted_out       = to_bank_q;
  assign from_bank_packet_ack_flatted_out = reset_in ? fb_ack : '0;
  assign output_packet_flatted_out        = out_q;
  assign route_error_out                  = route_err;
endmodule
